regfile_2w2r_sb: RTL and testbench

- Parametrised successor to the single-write MIPS register file.
- Two write ports (ALU writeback and load writeback) and two combinational read ports.
- Optional same-cycle write-to-read bypass, synchronous clear of all registers, and a per-register busy scoreboard for pipeline hazard detection.
- Sits between the decode stage (reads, busy checks) and the writeback stage (writes).

---
 rtl/regfile_pkg.sv | 10 +
 rtl/reg_scoreboard.sv | 66 ++++++
 rtl/regfile_2w2r_sb.sv | 103 ++++++++++
 tb/tb_regfile_2w2r_sb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the dual-write register file
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_IDX   = 0;
    // Write port whose data wins when both ports target the same index
    localparam int PRIO_PORT  = 1;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy vector with two bypass-masked lookups
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_idx,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_idx,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_idx,
    input  logic [ADDR_W-1:0] rd_a_idx,
    input  logic [ADDR_W-1:0] rd_b_idx,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == ADDR_W'(ZERO_IDX));
    endfunction

    always_comb begin
        busy_d = busy_q;
        if (rst) begin
            busy_d = '0;
        end else begin
            if (wr0_en) busy_d[wr0_idx] = 1'b0;
            if (wr1_en) busy_d[wr1_idx] = 1'b0;
            // A new mark supersedes a completing write to the same register
            if (mark_en) busy_d[mark_idx] = 1'b1;
            if (ZERO_REG != 0) busy_d[ZERO_IDX] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end

    function automatic logic lookup(input logic [ADDR_W-1:0] idx);
        logic wr_hit;
        logic mark_hit;
        wr_hit   = (wr0_en && wr0_idx == idx) || (wr1_en && wr1_idx == idx);
        mark_hit = mark_en && mark_idx == idx;
        if (is_zero(idx))
            return 1'b0;
        if ((BYPASS != 0) && !rst && wr_hit && !mark_hit)
            return 1'b0;
        return busy_q[idx];
    endfunction

    always_comb begin
        busy_a = lookup(rd_a_idx);
        busy_b = lookup(rd_b_idx);
    end

endmodule

// File: rtl/regfile_2w2r_sb.sv
// rtl/regfile_2w2r_sb.sv - two-write, two-read register file with bypass and busy scoreboard
module regfile_2w2r_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWrite0,
    input  logic [ADDR_W-1:0] writeReg0,
    input  logic [DATA_W-1:0] writeData0,
    input  logic              regWrite1,
    input  logic [ADDR_W-1:0] writeReg1,
    input  logic [DATA_W-1:0] writeData1,
    input  logic [ADDR_W-1:0] readReg1,
    output logic [DATA_W-1:0] readData1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData2,
    input  logic              markBusy,
    input  logic [ADDR_W-1:0] markReg,
    output logic              busy1,
    output logic              busy2
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int LO_PORT  = 1 - PRIO_PORT;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              wr_en   [2];
    logic [ADDR_W-1:0] wr_idx  [2];
    logic [DATA_W-1:0] wr_data [2];

    always_comb begin
        wr_en[0]   = regWrite0;
        wr_idx[0]  = writeReg0;
        wr_data[0] = writeData0;
        wr_en[1]   = regWrite1;
        wr_idx[1]  = writeReg1;
        wr_data[1] = writeData1;
    end

    function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == ADDR_W'(ZERO_IDX));
    endfunction

    // Lower-priority port applied first so the priority port overwrites it
    always_comb begin
        regs_d = regs_q;
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
        end else begin
            if (wr_en[LO_PORT] && !is_zero(wr_idx[LO_PORT]))
                regs_d[wr_idx[LO_PORT]] = wr_data[LO_PORT];
            if (wr_en[PRIO_PORT] && !is_zero(wr_idx[PRIO_PORT]))
                regs_d[wr_idx[PRIO_PORT]] = wr_data[PRIO_PORT];
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] val;
        val = regs_q[idx];
        if ((BYPASS != 0) && !rst) begin
            if (wr_en[LO_PORT] && wr_idx[LO_PORT] == idx) val = wr_data[LO_PORT];
            if (wr_en[PRIO_PORT] && wr_idx[PRIO_PORT] == idx) val = wr_data[PRIO_PORT];
        end
        if (is_zero(idx)) val = '0;
        return val;
    endfunction

    always_comb begin
        readData1 = read_port(readReg1);
        readData2 = read_port(readReg2);
    end

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (regWrite0),
        .wr0_idx  (writeReg0),
        .wr1_en   (regWrite1),
        .wr1_idx  (writeReg1),
        .mark_en  (markBusy),
        .mark_idx (markReg),
        .rd_a_idx (readReg1),
        .rd_b_idx (readReg2),
        .busy_a   (busy1),
        .busy_b   (busy2)
    );

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// tb/tb_regfile_2w2r_sb.sv - directed-vector bench for regfile_2w2r_sb with and without bypass
module tb_regfile_2w2r_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        regWrite0, regWrite1, markBusy;
    logic [4:0]  writeReg0, writeReg1, readReg1, readReg2, markReg;
    logic [31:0] writeData0, writeData1;
    logic [31:0] rd1_bp, rd2_bp, rd1_nb, rd2_nb;
    logic        busy1_bp, busy2_bp, busy1_nb, busy2_nb;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .regWrite0(regWrite0), .writeReg0(writeReg0), .writeData0(writeData0),
        .regWrite1(regWrite1), .writeReg1(writeReg1), .writeData1(writeData1),
        .readReg1(readReg1), .readData1(rd1_bp),
        .readReg2(readReg2), .readData2(rd2_bp),
        .markBusy(markBusy), .markReg(markReg),
        .busy1(busy1_bp), .busy2(busy2_bp)
    );

    regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .regWrite0(regWrite0), .writeReg0(writeReg0), .writeData0(writeData0),
        .regWrite1(regWrite1), .writeReg1(writeReg1), .writeData1(writeData1),
        .readReg1(readReg1), .readData1(rd1_nb),
        .readReg2(readReg2), .readData2(rd2_nb),
        .markBusy(markBusy), .markReg(markReg),
        .busy1(busy1_nb), .busy2(busy2_nb)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regWrite0 = 1'b0;
        regWrite1 = 1'b0;
        markBusy  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        writeReg0 = '0; writeReg1 = '0; writeData0 = '0; writeData1 = '0;
        readReg1 = 5'd5; readReg2 = 5'd31; markReg = '0;

        tick(); tick();
        rst = 1'b0;
        #1;
        check_vec("rst_rd1", rd1_bp, 32'h0);
        check_vec("rst_rd2", rd2_bp, 32'h0);
        check_vec("rst_busy1", {31'b0, busy1_bp}, 32'h0);
        check_vec("rst_busy2", {31'b0, busy2_bp}, 32'h0);

        regWrite0 = 1'b1; writeReg0 = 5'd1; writeData0 = 32'h0A;
        tick();
        idle();
        regWrite1 = 1'b1; writeReg1 = 5'd2; writeData1 = 32'h0B;
        tick();
        idle();
        readReg1 = 5'd1; readReg2 = 5'd2;
        #1;
        check_vec("wr_p0", rd1_bp, 32'h0A);
        check_vec("wr_p1", rd2_bp, 32'h0B);
        check_vec("wr_p0_nb", rd1_nb, 32'h0A);

        regWrite0 = 1'b1; writeReg0 = 5'd3; writeData0 = 32'h11;
        regWrite1 = 1'b1; writeReg1 = 5'd3; writeData1 = 32'h22;
        tick();
        idle();
        regWrite0 = 1'b1; writeReg0 = 5'd0; writeData0 = 32'h0C;
        readReg1 = 5'd0;
        #1;
        check_vec("zero_no_bypass", rd1_bp, 32'h0);
        tick();
        idle();
        readReg1 = 5'd3; readReg2 = 5'd0;
        #1;
        check_vec("conflict_p1_wins", rd1_bp, 32'h22);
        check_vec("zero_reg_read", rd2_bp, 32'h0);

        readReg1 = 5'd4;
        regWrite0 = 1'b1; writeReg0 = 5'd4; writeData0 = 32'h55;
        #1;
        check_vec("bypass_same_cycle", rd1_bp, 32'h55);
        check_vec("nobypass_old", rd1_nb, 32'h0);
        tick();
        idle();
        #1;
        check_vec("nobypass_next", rd1_nb, 32'h55);

        readReg2 = 5'd6;
        regWrite0 = 1'b1; writeReg0 = 5'd6; writeData0 = 32'h66;
        regWrite1 = 1'b1; writeReg1 = 5'd6; writeData1 = 32'h77;
        #1;
        check_vec("bypass_prio", rd2_bp, 32'h77);
        tick();
        idle();

        readReg1 = 5'd7;
        markBusy = 1'b1; markReg = 5'd7;
        #1;
        check_vec("mark_not_yet", {31'b0, busy1_bp}, 32'h0);
        tick();
        idle();
        #1;
        check_vec("busy_set", {31'b0, busy1_bp}, 32'h1);
        check_vec("busy_set_nb", {31'b0, busy1_nb}, 32'h1);
        regWrite1 = 1'b1; writeReg1 = 5'd7; writeData1 = 32'h70;
        #1;
        check_vec("busy_bypass_clr", {31'b0, busy1_bp}, 32'h0);
        check_vec("busy_nb_held", {31'b0, busy1_nb}, 32'h1);
        tick();
        idle();
        #1;
        check_vec("busy_clr_edge", {31'b0, busy1_bp}, 32'h0);
        check_vec("busy_clr_edge_nb", {31'b0, busy1_nb}, 32'h0);

        markBusy = 1'b1; markReg = 5'd7;
        regWrite0 = 1'b1; writeReg0 = 5'd7; writeData0 = 32'h71;
        #1;
        check_vec("mark_wr_comb", {31'b0, busy1_bp}, 32'h0);
        tick();
        idle();
        #1;
        check_vec("mark_wr_stays", {31'b0, busy1_bp}, 32'h1);
        check_vec("mark_wr_data", rd1_bp, 32'h71);

        readReg2 = 5'd0;
        markBusy = 1'b1; markReg = 5'd0;
        tick();
        idle();
        #1;
        check_vec("mark_zero_ign", {31'b0, busy2_bp}, 32'h0);

        regWrite0 = 1'b1; writeReg0 = 5'd9; writeData0 = 32'h99;
        tick();
        idle();
        markBusy = 1'b1; markReg = 5'd9;
        tick();
        idle();
        readReg1 = 5'd9; readReg2 = 5'd3;
        #1;
        check_vec("pre_rst_busy9", {31'b0, busy1_bp}, 32'h1);
        check_vec("pre_rst_reg9", rd1_bp, 32'h99);
        rst = 1'b1;
        regWrite1 = 1'b1; writeReg1 = 5'd9; writeData1 = 32'hFF;
        markBusy = 1'b1; markReg = 5'd9;
        #1;
        check_vec("rst_no_bypass", rd1_bp, 32'h99);
        check_vec("rst_busy_stored", {31'b0, busy1_bp}, 32'h1);
        tick();
        rst = 1'b0;
        idle();
        #1;
        check_vec("post_rst_reg9", rd1_bp, 32'h0);
        check_vec("post_rst_busy9", {31'b0, busy1_bp}, 32'h0);
        check_vec("post_rst_reg3", rd2_bp, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
